sra_seq_ctrl: RTL and testbench



---
 rtl/sra_seq_ctrl.sv | 66 ++++++
 tb/tb_sra_seq_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sra_seq_ctrl.sv
// sra_seq_ctrl: handshaked sequencer stepping the SRA datapath through its five control words
module sra_seq_ctrl #(
  parameter int WORD_SIZE = 19,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  output logic [WORD_SIZE:0]   ctrl_word,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4} state_t;
  state_t state, next;
  logic s3_hold;
  logic accept;
  logic [19:0] word;
  assign start_ready = (state == IDLE) || (state == S4);
  assign accept = start_valid && start_ready;
  assign res_valid = (state == S3);
  assign busy = (state != IDLE);
  assign ctrl_word = (WORD_SIZE + 1)'(word);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s3_hold <= 1'b0;
      op_count <= '0;
    end else begin
      state <= next;
      s3_hold <= (state == S3) && !res_ready;
      if (res_valid && res_ready) op_count <= op_count + CNT_W'(1);
    end
  end
  // a stalled S3 keeps driving the bus but stops rewriting R3
  always_comb begin
    next = IDLE;
    word = 20'h0;
    case (state)
      IDLE: next = accept ? S0 : IDLE;
      S0: begin
        next = S1;
        word = {5'h19, 10'h286, 4'h0, 1'b0};
      end
      S1: begin
        next = S2;
        word = {5'h11, 10'h125, 4'h1, 1'b0};
      end
      S2: begin
        next = S3;
        word = {5'h09, 10'h056, 4'h2, 1'b0};
      end
      S3: begin
        next = res_ready ? S4 : S3;
        word = {s3_hold ? 5'h00 : 5'h04, 10'h010, 4'h8, 1'b1};
      end
      S4: begin
        next = accept ? S0 : IDLE;
        word = {5'h03, 10'h018, 4'h4, 1'b0};
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sra_seq_ctrl.sv
// tb_sra_seq_ctrl: table-driven directed check of sra_seq_ctrl plus stall/reset/wrap sequences
module tb_sra_seq_ctrl;
  localparam logic [19:0] W0 = {5'h19, 10'h286, 4'h0, 1'b0};
  localparam logic [19:0] W1 = {5'h11, 10'h125, 4'h1, 1'b0};
  localparam logic [19:0] W2 = {5'h09, 10'h056, 4'h2, 1'b0};
  localparam logic [19:0] W3 = {5'h04, 10'h010, 4'h8, 1'b1};
  localparam logic [19:0] W3H = {5'h00, 10'h010, 4'h8, 1'b1};
  localparam logic [19:0] W4 = {5'h03, 10'h018, 4'h4, 1'b0};
  logic clk = 0;
  logic reset, start_valid, res_ready;
  logic start_ready, res_valid, busy;
  logic [19:0] ctrl_word;
  logic [7:0] op_count;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic rst, sv, rr;
    logic [30:0] exp;
  } vec_t;
  vec_t tbl[$];
  sra_seq_ctrl #(.WORD_SIZE(19), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .ctrl_word(ctrl_word), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  task automatic add(input logic rst, sv, rr, input logic [19:0] cw,
                     input logic rv, b, sr, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst;
    v.sv = sv;
    v.rr = rr;
    v.exp = {cw, rv, b, sr, cnt};
    tbl.push_back(v);
  endtask
  task automatic step(input logic rst, sv, rr);
    @(negedge clk);
    reset = rst;
    start_valid = sv;
    res_ready = rr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [30:0] act, input logic [30:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got cw=%h rv=%b busy=%b sr=%b cnt=%0d, expected cw=%h rv=%b busy=%b sr=%b cnt=%0d",
               name, act[30:11], act[10], act[9], act[8], act[7:0],
               exp[30:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask
  function automatic logic [30:0] outs();
    return {ctrl_word, res_valid, busy, start_ready, op_count};
  endfunction
  initial begin
    reset = 1;
    start_valid = 0;
    res_ready = 0;
    add(1, 0, 0, 20'h0, 0, 0, 1, 0);
    add(1, 0, 0, 20'h0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 20'h0, 0, 0, 1, 0);
    // single op, ready consumer
    add(0, 1, 1, W0, 0, 1, 0, 0);
    add(0, 0, 1, W1, 0, 1, 0, 0);
    add(0, 0, 1, W2, 0, 1, 0, 0);
    add(0, 0, 1, W3, 1, 1, 0, 0);
    add(0, 0, 1, W4, 0, 1, 1, 1);
    add(0, 0, 1, 20'h0, 0, 0, 1, 1);
    // three-cycle stall in S3
    add(0, 1, 0, W0, 0, 1, 0, 1);
    add(0, 0, 0, W1, 0, 1, 0, 1);
    add(0, 0, 0, W2, 0, 1, 0, 1);
    add(0, 0, 0, W3, 1, 1, 0, 1);
    add(0, 0, 0, W3H, 1, 1, 0, 1);
    add(0, 0, 0, W3H, 1, 1, 0, 1);
    add(0, 0, 0, W3H, 1, 1, 0, 1);
    add(0, 0, 1, W4, 0, 1, 1, 2);
    add(0, 0, 0, 20'h0, 0, 0, 1, 2);
    // back-to-back after a fresh reset
    add(1, 0, 0, 20'h0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 1, W0, 0, 1, 0, 8'(k));
      add(0, 1, 1, W1, 0, 1, 0, 8'(k));
      add(0, 1, 1, W2, 0, 1, 0, 8'(k));
      add(0, 1, 1, W3, 1, 1, 0, 8'(k));
      add(0, 1, 1, W4, 0, 1, 1, 8'(k + 1));
    end
    add(0, 0, 1, 20'h0, 0, 0, 1, 3);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].rr);
      chk($sformatf("row%0d", i), outs(), tbl[i].exp);
    end
    // reset during the second stall cycle abandons the op and clears the count
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("stall_entry", outs(), {W3, 1'b1, 1'b1, 1'b0, 8'd3});
    step(0, 0, 0);
    chk("stall_1", outs(), {W3H, 1'b1, 1'b1, 1'b0, 8'd3});
    step(1, 0, 1);
    chk("reset_mid_stall", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 8'd0});
    step(0, 0, 1);
    chk("after_reset_idle", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 8'd0});
    // 255 back-to-back ops, then one more to wrap
    for (int i = 0; i < 255 * 5; i++) step(0, 1, 1);
    chk("preload_255", outs(), {W4, 1'b0, 1'b1, 1'b1, 8'd255});
    step(0, 0, 1);
    chk("preload_idle", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 8'd255});
    step(0, 1, 1);
    chk("wrap_s0", outs(), {W0, 1'b0, 1'b1, 1'b0, 8'd255});
    step(0, 0, 1);
    chk("wrap_s1", outs(), {W1, 1'b0, 1'b1, 1'b0, 8'd255});
    step(0, 1, 1);
    chk("ignore_s2", outs(), {W2, 1'b0, 1'b1, 1'b0, 8'd255});
    step(0, 0, 1);
    chk("wrap_s3", outs(), {W3, 1'b1, 1'b1, 1'b0, 8'd255});
    step(0, 0, 1);
    chk("wrap_s4", outs(), {W4, 1'b0, 1'b1, 1'b1, 8'd0});
    step(0, 0, 1);
    chk("wrap_idle", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 8'd0});
    step(0, 0, 1);
    chk("no_extra_op", outs(), {20'h0, 1'b0, 1'b0, 1'b1, 8'd0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
